regfile_dump: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_dump_if.sv | 33 +++
 rtl/pair_buf.sv | 47 ++++
 rtl/regfile_dump.sv | 112 +++++++++++
 tb/tb_regfile_dump.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared parameters and FSM state type for the register-file dump engine.
package regfile_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND0,
    SEND1,
    FIN
  } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Bundle of the dump engine's control, register-file read and stream signals.
interface regfile_dump_if #(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
);

  logic          start;
  logic [AW-1:0] lo;
  logic [AW-1:0] hi;
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] dout;
  logic [AW-1:0] dnum;
  logic          dvalid;
  logic          dready;
  logic          busy;
  logic          done;

  // Requester / register file / stream sink side
  modport master (
    output start, lo, hi, qa, qb, dready,
    input  rna, rnb, dout, dnum, dvalid, busy, done
  );

  // Dump engine side
  modport slave (
    input  start, lo, hi, qa, qb, dready,
    output rna, rnb, dout, dnum, dvalid, busy, done
  );

endinterface

// File: rtl/pair_buf.sv
// Two-entry holding buffer: snapshots both read ports and presents one entry.
module pair_buf #(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  input  logic [AW-1:0] num_a,
  input  logic [AW-1:0] num_b,
  input  logic          show,
  input  logic          sel,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] dnum
);

  logic [DW-1:0] val0, val1;
  logic [AW-1:0] num0, num1;

  // Capture both read ports on the READ edge; later regfile writes cannot disturb them
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      val0 <= '0;
      val1 <= '0;
      num0 <= '0;
      num1 <= '0;
    end else if (load) begin
      val0 <= qa;
      val1 <= qb;
      num0 <= num_a;
      num1 <= num_b;
    end
  end

  // Present the selected entry while streaming, zero otherwise
  always_comb begin
    dout = '0;
    dnum = '0;
    if (show) begin
      dout = sel ? val1 : val0;
      dnum = sel ? num1 : num0;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Register-range dump engine: reads two registers per pass and streams them
// in ascending order over a valid/ready channel.
module regfile_dump #(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
) (
  input logic           clk,
  input logic           clr,
  regfile_dump_if.slave bus
);

  import regfile_pkg::*;

  // One extra pointer bit so hi = max register terminates without wrapping
  localparam int unsigned PW = AW + 1;

  state_t        state, state_nx;
  logic [PW-1:0] n, n_nx;
  logic [PW-1:0] limit, limit_nx;
  logic          load;
  logic          show;
  logic          sel;

  // State, pointer and limit registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      n     <= '0;
      limit <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      limit <= limit_nx;
    end
  end

  // Next-state, pointer advance and buffer load decisions
  always_comb begin
    state_nx = state;
    n_nx     = n;
    limit_nx = limit;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.lo <= bus.hi) begin
            n_nx     = {1'b0, bus.lo};
            limit_nx = {1'b0, bus.hi};
            state_nx = READ;
          end else begin
            state_nx = FIN;
          end
        end
      end
      READ: begin
        load     = 1'b1;
        state_nx = SEND0;
      end
      SEND0: begin
        if (bus.dready) begin
          state_nx = ((n + PW'(1)) <= limit) ? SEND1 : FIN;
        end
      end
      SEND1: begin
        if (bus.dready) begin
          n_nx     = n + PW'(2);
          state_nx = ((n + PW'(2)) <= limit) ? READ : FIN;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status, stream-valid and read-port addressing derived from state
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == FIN);
    bus.dvalid = (state == SEND0) || (state == SEND1);
    show       = bus.dvalid;
    sel        = (state == SEND1);
    bus.rna    = '0;
    bus.rnb    = '0;
    // n is stable from READ through SEND1, so the read numbers hold without extra registers
    if ((state == READ) || (state == SEND0) || (state == SEND1)) begin
      bus.rna = n[AW-1:0];
      bus.rnb = n[AW-1:0] + AW'(1);
    end
  end

  pair_buf #(
    .DW(DW),
    .AW(AW)
  ) u_pair_buf (
    .clk   (clk),
    .clr   (clr),
    .load  (load),
    .qa    (bus.qa),
    .qb    (bus.qb),
    .num_a (bus.rna),
    .num_b (bus.rnb),
    .show  (show),
    .sel   (sel),
    .dout  (bus.dout),
    .dnum  (bus.dnum)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: vector table, random ranges and
// hand-written snapshot, ignore and reset sequences.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  regfile_dump_if #(.DW(32), .AW(5)) bus();

  logic [31:0] regs [32];
  assign bus.qa = regs[bus.rna];
  assign bus.qb = regs[bus.rnb];

  regfile_dump #(.DW(32), .AW(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int lo;
    int hi;
    int pct;
    int exp_beats;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic init_regs(input bit rnd);
    for (int i = 0; i < 32; i++) regs[i] = rnd ? $urandom : i * 32'h11;
  endtask

  // One dump: the model is simply the ordered list of (number, value) in [lo..hi]
  // taken before the run starts; writes are only made to already-read registers.
  task automatic run_dump(input int lo_i, input int hi_i, input int pct, input int exp_beats,
                          input int wr_cyc, input int wr_addr, input logic [31:0] wr_data,
                          input int sb_cyc);
    int          exp_n [$];
    logic [31:0] exp_v [$];
    int          beats = 0, dones = 0, done_cyc = -1, first_cyc = -1;
    bit          stalled = 0;
    logic [31:0] pd = '0;
    logic [4:0]  pn = '0;
    for (int k = lo_i; k <= hi_i; k++) begin
      exp_n.push_back(k);
      exp_v.push_back(regs[k]);
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.lo     = 5'(lo_i);
    bus.hi     = 5'(hi_i);
    bus.dready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (stalled) begin
        chk("stall_dvalid", bus.dvalid, 1);
        chk("stall_dout", bus.dout, pd);
        chk("stall_dnum", bus.dnum, pn);
      end
      if (c == wr_cyc) regs[wr_addr] = wr_data;
      if (c == sb_cyc) begin
        bus.start = 1'b1;
        bus.lo    = 5'd0;
        bus.hi    = 5'd31;
      end else begin
        bus.start = 1'b0;
      end
      bus.dready = ($urandom_range(99) < pct);
      if (bus.dvalid && first_cyc < 0) first_cyc = c;
      if (bus.done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.dvalid && bus.dready) begin
        if (beats < exp_n.size()) begin
          chk("beat_dnum", bus.dnum, exp_n[beats]);
          chk("beat_dout", bus.dout, exp_v[beats]);
          chk("beat_rna", bus.rna, (lo_i + 2 * (beats / 2)) % 32);
        end else begin
          chk("extra_beat", 1, 0);
        end
        beats++;
      end
      stalled = bus.dvalid && !bus.dready;
      pd = bus.dout;
      pn = bus.dnum;
      if (done_cyc > 0 && c == done_cyc + 1) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_rna", bus.rna, 0);
      end
      if (done_cyc > 0 && c >= done_cyc + 2) break;
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.dready = 1'b0;
    chk("beat_count", beats, exp_beats);
    chk("done_pulses", dones, 1);
    if (pct >= 100) begin
      if (exp_beats > 0) begin
        chk("first_beat_cycle", first_cyc, 2);
        chk("done_cycle", done_cyc, (exp_beats + 1) / 2 + exp_beats + 1);
      end else begin
        chk("empty_done_cycle", done_cyc, 1);
        chk("empty_no_valid", first_cyc, -1);
      end
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.lo     = '0;
    bus.hi     = '0;
    bus.dready = 1'b0;
    init_regs(0);

    vecs[0] = '{lo: 0,  hi: 31, pct: 100, exp_beats: 32};
    vecs[1] = '{lo: 3,  hi: 5,  pct: 100, exp_beats: 3};
    vecs[2] = '{lo: 31, hi: 31, pct: 100, exp_beats: 1};
    vecs[3] = '{lo: 9,  hi: 2,  pct: 100, exp_beats: 0};
    vecs[4] = '{lo: 0,  hi: 0,  pct: 100, exp_beats: 1};
    vecs[5] = '{lo: 10, hi: 20, pct: 30,  exp_beats: 11};
    vecs[6] = '{lo: 0,  hi: 31, pct: 30,  exp_beats: 32};
    vecs[7] = '{lo: 30, hi: 31, pct: 70,  exp_beats: 2};
    vecs[8] = '{lo: 4,  hi: 7,  pct: 100, exp_beats: 4};
    vecs[9] = '{lo: 29, hi: 31, pct: 100, exp_beats: 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rna", bus.rna, 0);
    chk("rst_rnb", bus.rnb, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dnum", bus.dnum, 0);
    clr = 1'b0;

    foreach (vecs[i]) run_dump(vecs[i].lo, vecs[i].hi, vecs[i].pct, vecs[i].exp_beats, -1, 0, '0, -1);

    // Random ranges, contents and backpressure
    for (int r = 0; r < 8; r++) begin
      int a, b, p;
      init_regs(1);
      a = $urandom_range(31);
      b = $urandom_range(31);
      p = (r % 2 == 0) ? 30 : $urandom_range(100, 20);
      run_dump(a, b, p, (a <= b) ? b - a + 1 : 0, -1, 0, '0, -1);
    end

    // Snapshot: r7 is read at the first READ edge and overwritten just after;
    // a start issued mid-dump must be ignored
    init_regs(0);
    run_dump(6, 9, 100, 4, 2, 7, 32'hDEADBEEF, 3);
    chk("r7_written", regs[7], 32'hDEADBEEF);

    // Reset during SEND1 aborts without a done pulse
    init_regs(0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.lo     = 5'd0;
    bus.hi     = 5'd5;
    bus.dready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_dvalid", bus.dvalid, 1);
    chk("pre_rst_dnum", bus.dnum, 1);
    clr = 1'b1;
    #1;
    chk("mid_rst_dvalid", bus.dvalid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_dnum", bus.dnum, 0);
    chk("mid_rst_rna", bus.rna, 0);
    @(negedge clk);
    chk("mid_rst_done", bus.done, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
    run_dump(2, 4, 100, 3, -1, 0, '0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
